// File: rtl/basket_pkg.sv
// Shared definitions for the basket controller: command op codes, FSM states
// and the default unit-price table.
package basket_pkg;

    localparam int NUM_PRODUCTS = 8;

    typedef enum logic [1:0] {
        OP_ADD    = 2'b00,
        OP_CANCEL = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        SUM  = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_PRICE [NUM_PRODUCTS] = '{10, 25, 40, 5, 60, 15, 30, 99};

endpackage

// File: rtl/product_price_rom.sv
// Combinational unit-price lookup by product ID; also used by the display logic.
module product_price_rom
    import basket_pkg::*;
#(
    parameter int PRICE_W = 8
) (
    input  logic [2:0]         product_id,
    output logic [PRICE_W-1:0] price
);

    assign price = PRICE_W'(DEFAULT_PRICE[product_id]);

endmodule

// File: rtl/basket_controller.sv
// Per-product quantity table with a serial 8-cycle total/item-count recompute.
// Optional macro BASKET_SAT_ERR_EN: reject overflowing ADDs and pulse add_err.
module basket_controller
    import basket_pkg::*;
#(
    parameter int QTY_W   = 4,
    parameter int PRICE_W = 8,
    parameter int TOTAL_W = 15
) (
    input  logic                      CLOCK_50,
    input  logic                      RESET_N,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [2:0]                cmd_product_id,
    input  logic [2:0]                cmd_quantity,
    output logic [NUM_PRODUCTS*QTY_W-1:0] qty_flat,
    output logic [TOTAL_W-1:0]        total_price,
    output logic                      total_valid,
    output logic [3:0]                item_count,
    output logic                      add_err
);

    localparam logic [QTY_W-1:0] QTY_MAX = '1;

    state_e                     state, state_next;
    logic [QTY_W-1:0]           qty [NUM_PRODUCTS];
    logic [2:0]                 idx;
    logic [TOTAL_W-1:0]         acc, acc_next;
    logic [3:0]                 cnt, cnt_next;
    logic                       accept, table_change;
    logic [QTY_W-1:0]           qty_cur;
    logic [PRICE_W-1:0]         price_cur;
    logic [QTY_W+PRICE_W-1:0]   prod;

    function automatic logic [QTY_W-1:0] sat_add(input logic [QTY_W-1:0] a,
                                                 input logic [2:0] b);
        logic [QTY_W:0] s;
        s = {1'b0, a} + (QTY_W+1)'(b);
        return s[QTY_W] ? QTY_MAX : s[QTY_W-1:0];
    endfunction

    product_price_rom #(.PRICE_W(PRICE_W)) u_price_rom (
        .product_id (idx),
        .price      (price_cur)
    );

    genvar g;
    generate
        for (g = 0; g < NUM_PRODUCTS; g++) begin : g_flat
            assign qty_flat[g*QTY_W +: QTY_W] = qty[g];
        end
    endgenerate

    assign accept    = cmd_valid && cmd_ready;
    assign qty_cur   = qty[idx];
    assign prod      = {{PRICE_W{1'b0}}, qty_cur} * {{QTY_W{1'b0}}, price_cur};
    assign acc_next  = acc + TOTAL_W'(prod);
    assign cnt_next  = cnt + 4'(qty_cur != '0);

`ifdef BASKET_SAT_ERR_EN
    logic add_reject;
    assign add_reject = (cmd_op == OP_ADD) && (cmd_quantity != 3'd0) &&
                        (({1'b0, qty[cmd_product_id]} + (QTY_W+1)'(cmd_quantity)) > (QTY_W+1)'(QTY_MAX));

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) add_err <= 1'b0;
        else          add_err <= accept && add_reject;
    end
`else
    assign add_err = 1'b0;
`endif

    // Only commands that actually modify the table start a recompute
    always_comb begin
        table_change = 1'b0;
        case (cmd_op)
            OP_ADD: begin
`ifdef BASKET_SAT_ERR_EN
                table_change = (cmd_quantity != 3'd0) && !add_reject;
`else
                table_change = (cmd_quantity != 3'd0);
`endif
            end
            OP_CANCEL, OP_CLEAR: table_change = 1'b1;
            default: table_change = 1'b0;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && table_change) state_next = SUM;
            SUM:  if (idx == 3'd7)            state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready   = (state == IDLE);
        total_valid = (state == IDLE);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_PRODUCTS; i++) qty[i] <= '0;
            idx         <= '0;
            acc         <= '0;
            cnt         <= '0;
            total_price <= '0;
            item_count  <= '0;
        end else if (state == IDLE) begin
            if (accept && table_change) begin
                case (cmd_op)
                    OP_ADD:    qty[cmd_product_id] <= sat_add(qty[cmd_product_id], cmd_quantity);
                    OP_CANCEL: qty[cmd_product_id] <= '0;
                    OP_CLEAR:  for (int i = 0; i < NUM_PRODUCTS; i++) qty[i] <= '0;
                    default: ;
                endcase
                idx <= '0;
                acc <= '0;
                cnt <= '0;
            end
        end else begin
            // Serial accumulate; the idx==7 step publishes the final values
            acc <= acc_next;
            cnt <= cnt_next;
            idx <= idx + 3'd1;
            if (idx == 3'd7) begin
                total_price <= acc_next;
                item_count  <= cnt_next;
            end
        end
    end

endmodule

// File: tb/tb_basket_controller.sv
// Directed self-checking bench for basket_controller (default and BASKET_SAT_ERR_EN builds).
module tb_basket_controller;

    logic        CLOCK_50 = 1'b0;
    logic        RESET_N;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_product_id;
    logic [2:0]  cmd_quantity;
    logic [31:0] qty_flat;
    logic [14:0] total_price;
    logic        total_valid;
    logic [3:0]  item_count;
    logic        add_err;

    int n_cmp = 0;
    int n_bad = 0;

    basket_controller dut (
        .CLOCK_50       (CLOCK_50),
        .RESET_N        (RESET_N),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_product_id (cmd_product_id),
        .cmd_quantity   (cmd_quantity),
        .qty_flat       (qty_flat),
        .total_price    (total_price),
        .total_valid    (total_valid),
        .item_count     (item_count),
        .add_err        (add_err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Wait (bounded) for ready, present one command for one accept edge, release it.
    task automatic issue(input logic [1:0] op, input logic [2:0] id, input logic [2:0] q);
        int n = 0;
        while (!cmd_ready && n < 30) begin tick(); n++; end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL issue_ready_timeout: got %b want 1", cmd_ready); end
        cmd_valid = 1'b1; cmd_op = op; cmd_product_id = id; cmd_quantity = q;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!cmd_ready && n < 30) begin tick(); n++; end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_product_id = 3'd0; cmd_quantity = 3'd0;
        repeat (3) tick();
        RESET_N = 1'b1;
        repeat (5) tick();
        n_cmp++; if (qty_flat    !== 32'h0) begin n_bad++; $display("FAIL reset_qty: got %h want 0", qty_flat); end
        n_cmp++; if (total_price !== 15'd0) begin n_bad++; $display("FAIL reset_total: got %0d want 0", total_price); end
        n_cmp++; if (item_count  !== 4'd0)  begin n_bad++; $display("FAIL reset_count: got %0d want 0", item_count); end
        n_cmp++; if (total_valid !== 1'b1)  begin n_bad++; $display("FAIL reset_valid: got %b want 1", total_valid); end
        n_cmp++; if (cmd_ready   !== 1'b1)  begin n_bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        n_cmp++; if (add_err     !== 1'b0)  begin n_bad++; $display("FAIL reset_add_err: got %b want 0", add_err); end
    endtask

    task automatic test_add_basic();
        int n;
        issue(2'b00, 3'd2, 3'd3);
        n_cmp++; if (qty_flat    !== 32'h0000_0300) begin n_bad++; $display("FAIL add_qty: got %h want 00000300", qty_flat); end
        n_cmp++; if (cmd_ready   !== 1'b0) begin n_bad++; $display("FAIL add_ready_drop: got %b want 0", cmd_ready); end
        n_cmp++; if (total_valid !== 1'b0) begin n_bad++; $display("FAIL add_valid_drop: got %b want 0", total_valid); end
        n_cmp++; if (total_price !== 15'd0) begin n_bad++; $display("FAIL add_total_hold: got %0d want 0", total_price); end
        wait_ready(n);
        n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL add_latency: got %0d want 8", n); end
        n_cmp++; if (total_price !== 15'd120) begin n_bad++; $display("FAIL add_total: got %0d want 120", total_price); end
        n_cmp++; if (item_count  !== 4'd1)   begin n_bad++; $display("FAIL add_count: got %0d want 1", item_count); end
        n_cmp++; if (total_valid !== 1'b1)   begin n_bad++; $display("FAIL add_valid: got %b want 1", total_valid); end
    endtask

    task automatic test_noop();
        issue(2'b00, 3'd1, 3'd0);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL noop_add_ready: got %b want 1", cmd_ready); end
        issue(2'b11, 3'd2, 3'd2);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL noop_rsvd_ready: got %b want 1", cmd_ready); end
        n_cmp++; if (qty_flat !== 32'h0000_0300) begin n_bad++; $display("FAIL noop_qty: got %h want 00000300", qty_flat); end
        n_cmp++; if (total_price !== 15'd120) begin n_bad++; $display("FAIL noop_total: got %0d want 120", total_price); end
    endtask

    task automatic test_multi();
        int n;
        for (int i = 0; i < 3; i++) begin issue(2'b00, 3'd2, 3'd4); wait_ready(n); end
        n_cmp++; if (qty_flat    !== 32'h0000_0F00) begin n_bad++; $display("FAIL multi_qty15: got %h want 00000f00", qty_flat); end
        n_cmp++; if (total_price !== 15'd600) begin n_bad++; $display("FAIL multi_total600: got %0d want 600", total_price); end
        issue(2'b00, 3'd5, 3'd2); wait_ready(n);
        n_cmp++; if (total_price !== 15'd630) begin n_bad++; $display("FAIL multi_total630: got %0d want 630", total_price); end
        n_cmp++; if (item_count  !== 4'd2)   begin n_bad++; $display("FAIL multi_count2: got %0d want 2", item_count); end
        issue(2'b01, 3'd2, 3'd0); wait_ready(n);
        n_cmp++; if (qty_flat    !== 32'h0020_0000) begin n_bad++; $display("FAIL cancel_qty: got %h want 00200000", qty_flat); end
        n_cmp++; if (total_price !== 15'd30) begin n_bad++; $display("FAIL cancel_total: got %0d want 30", total_price); end
        n_cmp++; if (item_count  !== 4'd1)  begin n_bad++; $display("FAIL cancel_count: got %0d want 1", item_count); end
    endtask

    task automatic test_saturation();
        int n;
        issue(2'b10, 3'd0, 3'd0); wait_ready(n);
        for (int i = 0; i < 3; i++) begin issue(2'b00, 3'd0, 3'd4); wait_ready(n); end
        n_cmp++; if (total_price !== 15'd120) begin n_bad++; $display("FAIL sat_pre_total: got %0d want 120", total_price); end
        issue(2'b00, 3'd0, 3'd4);
`ifdef BASKET_SAT_ERR_EN
        n_cmp++; if (add_err   !== 1'b1) begin n_bad++; $display("FAIL sat_err_pulse: got %b want 1", add_err); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL sat_ready_kept: got %b want 1", cmd_ready); end
        n_cmp++; if (qty_flat  !== 32'h0000_000C) begin n_bad++; $display("FAIL sat_qty_kept: got %h want 0000000c", qty_flat); end
        tick();
        n_cmp++; if (add_err   !== 1'b0) begin n_bad++; $display("FAIL sat_err_width: got %b want 0", add_err); end
        n_cmp++; if (total_price !== 15'd120) begin n_bad++; $display("FAIL sat_total_kept: got %0d want 120", total_price); end
`else
        n_cmp++; if (add_err   !== 1'b0) begin n_bad++; $display("FAIL sat_no_err: got %b want 0", add_err); end
        n_cmp++; if (qty_flat  !== 32'h0000_000F) begin n_bad++; $display("FAIL sat_qty15: got %h want 0000000f", qty_flat); end
        wait_ready(n);
        n_cmp++; if (total_price !== 15'd150) begin n_bad++; $display("FAIL sat_total150: got %0d want 150", total_price); end
`endif
    endtask

    task automatic test_back_to_back();
        int n;
        logic r;
        logic [14:0] exp_total;
`ifdef BASKET_SAT_ERR_EN
        exp_total = 15'd125;
`else
        exp_total = 15'd155;
`endif
        issue(2'b00, 3'd3, 3'd1);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_product_id = 3'd0; cmd_quantity = 3'd0;
        n = 0;
        r = cmd_ready;
        while (!r && n < 30) begin r = cmd_ready; tick(); n++; end
        cmd_valid = 1'b0;
        n_cmp++; if (n !== 9) begin n_bad++; $display("FAIL b2b_accept_edge: got %0d want 9", n); end
        n_cmp++; if (qty_flat !== 32'h0) begin n_bad++; $display("FAIL b2b_clear_qty: got %h want 0", qty_flat); end
        n_cmp++; if (total_price !== exp_total) begin n_bad++; $display("FAIL b2b_prev_total: got %0d want %0d", total_price, exp_total); end
        wait_ready(n);
        n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL b2b_clear_latency: got %0d want 8", n); end
        n_cmp++; if (total_price !== 15'd0) begin n_bad++; $display("FAIL b2b_clear_total: got %0d want 0", total_price); end
        n_cmp++; if (item_count  !== 4'd0)  begin n_bad++; $display("FAIL b2b_clear_count: got %0d want 0", item_count); end
    endtask

    task automatic test_reset_mid_sum();
        int n;
        issue(2'b00, 3'd6, 3'd1); wait_ready(n);
        n_cmp++; if (total_price !== 15'd30) begin n_bad++; $display("FAIL rms_pre_total: got %0d want 30", total_price); end
        issue(2'b00, 3'd4, 3'd1);
        repeat (4) tick();
        #2 RESET_N = 1'b0;
        #1;
        n_cmp++; if (qty_flat    !== 32'h0) begin n_bad++; $display("FAIL rms_qty: got %h want 0", qty_flat); end
        n_cmp++; if (total_price !== 15'd0) begin n_bad++; $display("FAIL rms_total: got %0d want 0", total_price); end
        n_cmp++; if (item_count  !== 4'd0)  begin n_bad++; $display("FAIL rms_count: got %0d want 0", item_count); end
        n_cmp++; if (cmd_ready   !== 1'b1)  begin n_bad++; $display("FAIL rms_ready: got %b want 1", cmd_ready); end
        n_cmp++; if (total_valid !== 1'b1)  begin n_bad++; $display("FAIL rms_valid: got %b want 1", total_valid); end
        tick();
        RESET_N = 1'b1;
        tick();
        issue(2'b00, 3'd7, 3'd1); wait_ready(n);
        n_cmp++; if (qty_flat    !== 32'h1000_0000) begin n_bad++; $display("FAIL rms_add7_qty: got %h want 10000000", qty_flat); end
        n_cmp++; if (total_price !== 15'd99) begin n_bad++; $display("FAIL rms_add7_total: got %0d want 99", total_price); end
        n_cmp++; if (item_count  !== 4'd1)  begin n_bad++; $display("FAIL rms_add7_count: got %0d want 1", item_count); end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_noop();
        test_multi();
        test_saturation();
        test_back_to_back();
        test_reset_mid_sum();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
